display_scan_ctrl: RTL and testbench

// - Time-multiplexed scan controller for the 8-digit 7-segment display.
// - Generates the 3-bit digit index r_counter that drives the downstream nibble mux.
// - Takes the selected nibble back on digit_in, decodes it to active-low segments and drives active-low anodes.
// - Inserts a blanking gap between digits for ghost suppression and skips disabled digits.

---
 rtl/display_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit active-low 7-segment display.
// Optional decimal-point output is built when DISPLAY_DP_EN is defined.
module display_scan_ctrl #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] digit_en,
    input  logic [3:0] digit_in,
`ifdef DISPLAY_DP_EN
    input  logic [7:0] dp_mask,
    output logic       dp,
`endif
    output logic [2:0] r_counter,
    output logic [7:0] anodes,
    output logic [6:0] segments,
    output logic       frame_tick
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [2:0]    next_idx;

    // First enabled index at or after base, wrapping; callers guarantee en != 0.
    function automatic logic [2:0] first_from(input logic [2:0] base, input logic [7:0] en);
        logic [2:0] idx;
        logic       found;
        first_from = base;
        found      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = base + 3'(i);
            if (!found && en[idx]) begin
                first_from = idx;
                found      = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] lit_pattern(input logic [2:0] idx, input logic [7:0] en);
        lit_pattern = 8'hFF;
        if (en[idx]) lit_pattern[idx] = 1'b0;
    endfunction

    assign next_idx = first_from(r_counter + 3'd1, digit_en);

    // Outputs are computed from the state being entered, so anodes go dark on
    // the same edge that r_counter moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            r_counter  <= 3'd0;
            anodes     <= 8'hFF;
            frame_tick <= 1'b0;
`ifdef DISPLAY_DP_EN
            dp         <= 1'b1;
`endif
        end else begin
            frame_tick <= 1'b0;
            anodes     <= 8'hFF;
`ifdef DISPLAY_DP_EN
            dp         <= 1'b1;
`endif
            if (digit_en == 8'h00) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        r_counter <= first_from(r_counter, digit_en);
                        count     <= '0;
                        state     <= BLANK;
                    end
                    BLANK: begin
                        count <= count + 1'b1;
                        if (count == BLANK_LAST) begin
                            state  <= SHOW;
                            anodes <= lit_pattern(r_counter, digit_en);
`ifdef DISPLAY_DP_EN
                            dp     <= ~(dp_mask[r_counter] & digit_en[r_counter]);
`endif
                        end
                    end
                    SHOW: begin
                        if (count == SLOT_LAST) begin
                            r_counter  <= next_idx;
                            frame_tick <= (next_idx <= r_counter);
                            count      <= '0;
                            state      <= BLANK;
                        end else begin
                            count  <= count + 1'b1;
                            anodes <= lit_pattern(r_counter, digit_en);
`ifdef DISPLAY_DP_EN
                            dp     <= ~(dp_mask[r_counter] & digit_en[r_counter]);
`endif
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        segments = 7'h7F;
        case (digit_in)
            4'h0: segments = 7'h40;
            4'h1: segments = 7'h79;
            4'h2: segments = 7'h24;
            4'h3: segments = 7'h30;
            4'h4: segments = 7'h19;
            4'h5: segments = 7'h12;
            4'h6: segments = 7'h02;
            4'h7: segments = 7'h78;
            4'h8: segments = 7'h00;
            4'h9: segments = 7'h10;
            4'hA: segments = 7'h08;
            4'hB: segments = 7'h03;
            4'hC: segments = 7'h46;
            4'hD: segments = 7'h21;
            4'hE: segments = 7'h06;
            4'hF: segments = 7'h0E;
            default: segments = 7'h7F;
        endcase
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SLOT_CYCLES=8, BLANK_CYCLES=2.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] digit_en;
    logic [3:0] digit_in;
    logic [2:0] r_counter;
    logic [7:0] anodes;
    logic [6:0] segments;
    logic       frame_tick;
    logic       sweep_mode;
    logic [3:0] sweep_val;
`ifdef DISPLAY_DP_EN
    logic [7:0] dp_mask;
    logic       dp;
`endif

    int passed = 0;
    int total  = 0;

    display_scan_ctrl #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .digit_en   (digit_en),
        .digit_in   (digit_in),
`ifdef DISPLAY_DP_EN
        .dp_mask    (dp_mask),
        .dp         (dp),
`endif
        .r_counter  (r_counter),
        .anodes     (anodes),
        .segments   (segments),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always_comb begin
        digit_in = {1'b0, r_counter};
        if (sweep_mode) digit_in = sweep_val;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] en);
        reset    = 1'b1;
        digit_en = en;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        digit_en   = 8'hFF;
        sweep_mode = 1'b0;
        sweep_val  = 4'h0;
        tick();
        tick();
        total++;
        if (r_counter !== 3'd0 || anodes !== 8'hFF || frame_tick !== 1'b0)
            $display("FAIL reset_state: r=%0d an=%h ft=%b, want r=0 an=ff ft=0", r_counter, anodes, frame_tick);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_full_scan();
        logic [7:0] exp_an;
        logic [2:0] exp_r;
        for (int cyc = 0; cyc <= 64; cyc++) begin
            tick();
            exp_r  = 3'((cyc / 8) % 8);
            exp_an = ((cyc % 8) < 2) ? 8'hFF : ~(8'h01 << exp_r);
            total++;
            if (r_counter !== exp_r || anodes !== exp_an || frame_tick !== (cyc == 64))
                $display("FAIL full_scan cyc%0d: r=%0d an=%h ft=%b, want r=%0d an=%h ft=%b",
                         cyc, r_counter, anodes, frame_tick, exp_r, exp_an, (cyc == 64));
            else passed++;
        end
    endtask

    task automatic test_two_digits();
        logic [7:0] exp_an;
        logic [2:0] exp_r;
        do_reset(8'b0010_0100);
        for (int cyc = 0; cyc < 32; cyc++) begin
            tick();
            exp_r  = (((cyc / 8) % 2) == 0) ? 3'd2 : 3'd5;
            exp_an = ((cyc % 8) < 2) ? 8'hFF : ((exp_r == 3'd2) ? 8'hFB : 8'hDF);
            total++;
            if (r_counter !== exp_r || anodes !== exp_an || frame_tick !== (cyc == 16))
                $display("FAIL two_digits cyc%0d: r=%0d an=%h ft=%b, want r=%0d an=%h ft=%b",
                         cyc, r_counter, anodes, frame_tick, exp_r, exp_an, (cyc == 16));
            else passed++;
        end
    endtask

    task automatic test_single_digit();
        logic [7:0] exp_an;
        logic       exp_ft;
        do_reset(8'h10);
        for (int cyc = 0; cyc < 24; cyc++) begin
            tick();
            exp_an = ((cyc % 8) < 2) ? 8'hFF : 8'hEF;
            exp_ft = ((cyc % 8) == 0) && (cyc > 0);
            total++;
            if (r_counter !== 3'd4 || anodes !== exp_an || frame_tick !== exp_ft)
                $display("FAIL single_digit cyc%0d: r=%0d an=%h ft=%b, want r=4 an=%h ft=%b",
                         cyc, r_counter, anodes, frame_tick, exp_an, exp_ft);
            else passed++;
        end
    endtask

    task automatic test_segments();
        logic [6:0] seg_tab [16];
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        do_reset(8'hFF);
        for (int i = 0; i < 4; i++) tick();
        sweep_mode = 1'b1;
        for (int v = 0; v < 16; v++) begin
            sweep_val = 4'(v);
            #1;
            total++;
            if (segments !== seg_tab[v])
                $display("FAIL segments digit %h: got %b, want %b", sweep_val, segments, seg_tab[v]);
            else passed++;
        end
        sweep_mode = 1'b0;
    endtask

    task automatic test_digit_off();
        do_reset(8'hFF);
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (anodes !== 8'hFE) $display("FAIL digit_off_pre: an=%h, want fe", anodes);
        else passed++;
        digit_en = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (anodes !== 8'hFF || r_counter !== 3'd0)
                $display("FAIL digit_off_dark %0d: an=%h r=%0d, want ff r=0", i, anodes, r_counter);
            else passed++;
        end
        tick();
        total++;
        if (r_counter !== 3'd1 || anodes !== 8'hFF)
            $display("FAIL digit_off_advance: r=%0d an=%h, want r=1 an=ff", r_counter, anodes);
        else passed++;
    endtask

    task automatic test_disable_reenable();
        do_reset(8'hFF);
        for (int i = 0; i < 4; i++) tick();
        digit_en = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (anodes !== 8'hFF || r_counter !== 3'd0)
                $display("FAIL disable %0d: an=%h r=%0d, want ff r=0", i, anodes, r_counter);
            else passed++;
        end
        digit_en = 8'h80;
        tick();
        tick();
        total++;
        if (anodes !== 8'hFF || r_counter !== 3'd7)
            $display("FAIL reenable_blank: an=%h r=%0d, want ff r=7", anodes, r_counter);
        else passed++;
        tick();
        total++;
        if (anodes !== 8'h7F || r_counter !== 3'd7)
            $display("FAIL reenable_show: an=%h r=%0d, want 7f r=7", anodes, r_counter);
        else passed++;
    endtask

    task automatic test_reset_mid_show();
        do_reset(8'hFF);
        for (int i = 0; i < 29; i++) tick();
        total++;
        if (anodes !== 8'hF7 || r_counter !== 3'd3)
            $display("FAIL mid_show_pre: an=%h r=%0d, want f7 r=3", anodes, r_counter);
        else passed++;
        reset = 1'b1;
        tick();
        total++;
        if (r_counter !== 3'd0 || anodes !== 8'hFF || frame_tick !== 1'b0)
            $display("FAIL mid_show_reset: r=%0d an=%h ft=%b, want r=0 an=ff ft=0", r_counter, anodes, frame_tick);
        else passed++;
        reset = 1'b0;
    endtask

`ifdef DISPLAY_DP_EN
    task automatic test_dp();
        logic exp_dp;
        dp_mask = 8'h02;
        do_reset(8'hFF);
        for (int cyc = 0; cyc < 64; cyc++) begin
            tick();
            exp_dp = !((cyc / 8) == 1 && (cyc % 8) >= 2);
            total++;
            if (dp !== exp_dp) $display("FAIL dp cyc%0d: got %b, want %b", cyc, dp, exp_dp);
            else passed++;
        end
    endtask
`endif

    initial begin
`ifdef DISPLAY_DP_EN
        dp_mask = 8'h00;
`endif
        test_reset();
        test_full_scan();
        test_two_digits();
        test_single_digit();
        test_segments();
        test_digit_off();
        test_disable_reenable();
        test_reset_mid_show();
`ifdef DISPLAY_DP_EN
        test_dp();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
